// File: rtl/dot_product_engine.sv
// dot_product_engine
//   Streams VEC_LEN element pairs out of two synchronous-read operand
//   memories (mem1 = vector A, mem2 = vector B), multiplies each pair as
//   signed values and accumulates them. The sum is offered on a
//   valid/ready result port.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_start, i_base_addr    start request (IDLE only), first element address
//   o_a_read_en/_address    read port to mem1
//   i_a_data_in             mem1 registered data_out
//   o_b_read_en/_address    read port to mem2 (same timing/address as A)
//   i_b_data_in             mem2 registered data_out
//   o_busy                  high in every state except IDLE
//   o_result, o_result_valid, i_result_ready   result handshake
module dot_product_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int VEC_LEN    = 16,
   parameter int ACC_WIDTH  = 20
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   output logic                  o_a_read_en,
   output logic [ADDR_WIDTH-1:0] o_a_read_address,
   input  logic [DATA_WIDTH-1:0] i_a_data_in,
   output logic                  o_b_read_en,
   output logic [ADDR_WIDTH-1:0] o_b_read_address,
   input  logic [DATA_WIDTH-1:0] i_b_data_in,
   output logic                  o_busy,
   output logic [ACC_WIDTH-1:0]  o_result,
   output logic                  o_result_valid,
   input  logic                  i_result_ready
);

   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam int PW    = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [CNT_W-1:0]       r_cnt;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic                   r_ren;
   // [0]: memory outputs hold a requested element, [1]: r_prod holds a product
   logic [1:0]             r_vld_pipe;
   logic signed [PW-1:0]   r_prod;
   logic signed [ACC_WIDTH-1:0] r_acc;
   logic signed [ACC_WIDTH-1:0] r_result;
   logic                   r_busy;
   logic                   r_rv;

   logic                   w_accept;
   logic                   w_last_rd;
   logic                   w_last_acc;
   logic                   w_ren_d;
   logic                   w_busy_d;
   logic                   w_rv_d;
   logic signed [PW-1:0]   w_a_ext;
   logic signed [PW-1:0]   w_b_ext;
   logic signed [ACC_WIDTH-1:0] w_prod_ext;
   logic signed [ACC_WIDTH-1:0] w_sum;

   assign w_a_ext    = PW'($signed(i_a_data_in));
   assign w_b_ext    = PW'($signed(i_b_data_in));
   assign w_prod_ext = ACC_WIDTH'(r_prod);
   assign w_sum      = r_acc + w_prod_ext;

   assign w_accept   = (r_state == S_IDLE) && i_start;
   assign w_last_rd  = (r_state == S_READ) && (r_cnt == CNT_W'(VEC_LEN - 1));
   // Final product sits in r_prod once no further data is behind it.
   assign w_last_acc = (r_state == S_DRAIN) && r_vld_pipe[1] && !r_vld_pipe[0];

   // state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start)        w_next = S_READ;
         S_READ:  if (w_last_rd)      w_next = S_DRAIN;
         S_DRAIN: if (w_last_acc)     w_next = S_DONE;
         S_DONE:  if (i_result_ready) w_next = S_IDLE;
         default:                     w_next = S_IDLE;
      endcase
   end

   // output logic: next values of the registered status outputs
   always_comb begin
      w_ren_d  = (w_next == S_READ);
      w_busy_d = (w_next != S_IDLE);
      w_rv_d   = (w_next == S_DONE);
   end

   // datapath and registered outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt      <= '0;
         r_addr     <= '0;
         r_ren      <= 1'b0;
         r_vld_pipe <= '0;
         r_prod     <= '0;
         r_acc      <= '0;
         r_result   <= '0;
         r_busy     <= 1'b0;
         r_rv       <= 1'b0;
      end else begin
         r_ren  <= w_ren_d;
         r_busy <= w_busy_d;
         r_rv   <= w_rv_d;

         if (w_accept) begin
            r_addr <= i_base_addr;
            r_cnt  <= '0;
         end else if (r_state == S_READ) begin
            // address wraps naturally at 2**ADDR_WIDTH
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
         end

         r_vld_pipe <= {r_vld_pipe[0], r_ren};
         r_prod     <= w_a_ext * w_b_ext;

         if (w_accept)           r_acc <= '0;
         else if (r_vld_pipe[1]) r_acc <= w_sum;

         if (w_last_acc) r_result <= w_sum;
      end
   end

   assign o_a_read_en      = r_ren;
   assign o_b_read_en      = r_ren;
   assign o_a_read_address = r_addr;
   assign o_b_read_address = r_addr;
   assign o_busy           = r_busy;
   assign o_result         = r_result;
   assign o_result_valid   = r_rv;

endmodule

// File: doc/dot_product_engine.md
Name: dot_product_engine

Overview:
- Sequencer and MAC stage directly downstream of the two operand memories (mem1 holds vector A, mem2 holds vector B) in the dotProduct datapath.
- On start, streams VEC_LEN reads from each memory's read port, multiplies element pairs as signed values, and accumulates them.
- Presents the dot product on a valid/ready result port.

Parameters:
- DATA_WIDTH, 8: element width, signed two's complement; must match memory data_out width.
- ADDR_WIDTH, 4: memory read address width.
- VEC_LEN, 16: elements per dot product; legal range 1..2**ADDR_WIDTH.
- ACC_WIDTH, 20: accumulator and result width; the default holds 16 x (-128 x -128) without overflow.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first element address; captured on the accepted start.
- a_read_en  out  1  read enable to mem1.
- a_read_address  out  ADDR_WIDTH  read address to mem1.
- a_data_in  in  DATA_WIDTH  mem1 data_out; registered, valid in the cycle after the edge that sampled read_en.
- b_read_en  out  1  read enable to mem2; identical timing to a_read_en.
- b_read_address  out  ADDR_WIDTH  read address to mem2; always equal to a_read_address.
- b_data_in  in  DATA_WIDTH  mem2 data_out.
- busy  out  1  high in every state except IDLE.
- result  out  ACC_WIDTH  signed dot product; stable while result_valid is high.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE.
  - a/b_read_en = 0; addresses = 0.
  - busy = 0; result = 0; result_valid = 0.
  - Element counter, product register, pipeline valid bits and accumulator all = 0.
- All outputs are registered.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE -> READ: at the edge E0 where start = 1.
  - Accumulator cleared, base_addr captured, counter = 0.
  - read_en goes high after E0 with address = base_addr.
- READ: issues one read pair per cycle.
  - Element i uses address (base_addr + i) mod 2**ADDR_WIDTH; wrap-around is required.
  - After VEC_LEN reads (edges E1..E_VEC_LEN), read_en drops and the FSM moves to DRAIN.
- Pipeline, element i:
  - Memory samples the read at edge E(i+1); data is visible after E(i+1).
  - Product register captures the full-precision signed product of sign-extended a_data_in x b_data_in (2*DATA_WIDTH bits) at E(i+2).
  - Accumulator adds the sign-extended product at E(i+3).
  - A valid bit travels with each stage; only valid products are accumulated.
- DRAIN -> DONE: at the edge E(VEC_LEN+2), which performs the final accumulation.
  - result_valid = 1 and result = final sum at that same edge.
  - result_valid is first high VEC_LEN+2 edges after E0.
- DONE: result and result_valid held stable until an edge with result_ready = 1.
  - At that edge result_valid -> 0 and the FSM returns to IDLE.
  - result keeps its last value.
- Accumulator overflow wraps modulo 2**ACC_WIDTH; no saturation and no flag.
- start while busy (READ, DRAIN, DONE) is ignored, including in the cycle of the result handshake; a new start is accepted only from IDLE on a later edge.
- result_ready outside DONE has no effect.
- Reset asserted mid-operation aborts the computation; the partial sum is discarded. After release the block is in IDLE and needs a new start.
- VEC_LEN = 1: exactly one read cycle; result_valid high 3 edges after E0.

Test Plan:
- Basic:
  - Stimulus: VEC_LEN = 4, mem1[0..3] = 1, 2, 3, 4; mem2[0..3] = 5, 6, 7, 8; base 0; start pulse; result_ready = 1.
  - Required: read_en high for exactly 4 cycles with addresses 0, 1, 2, 3; result = 70 (0x00046); result_valid high 6 edges after start for 1 cycle.
- Signed extreme:
  - Stimulus: VEC_LEN = 16, all A = 0x80, all B = 0x80.
  - Required: result = 262144 (0x40000).
  - Stimulus: A = 0x7F, B = 0x80.
  - Required: result = -260096 (0xC0800).
- Address wrap:
  - Stimulus: VEC_LEN = 4, base 14, A[14, 15, 0, 1] = 2, 3, 4, 5, all B = 1.
  - Required: addresses 14, 15, 0, 1 in order; result = 14.
- Backpressure and ignored start:
  - Stimulus: hold result_ready = 0 for 5 cycles after result_valid; pulse start during READ and during DONE.
  - Required: result and valid stay stable; no extra read_en cycles; a single handshake returns busy to 0.
- Reset mid-operation:
  - Stimulus: assert rst during READ at element 2.
  - Required: read_en, busy and result_valid go low immediately, result = 0. A following start with basic data returns 70.
- Back-to-back:
  - Stimulus: accept a result, then start on the next cycle with different data.
  - Required: the second result is correct; nothing carries over from the first accumulation.
